load_scheduler: RTL

//  Sequences the FPGA-demo program driver: selects which stored program slot it loads, raises
//  its level 'drive', waits for load completion, holds the processor running for a dwell

---
 rtl/load_sched_pkg.sv | 24 ++
 rtl/sched_timer.sv | 31 +++
 rtl/load_scheduler.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/load_sched_pkg.sv
// rtl/load_sched_pkg.sv - shared types and defaults for the program-load scheduler
// Purpose : state encoding, default timing constants and counter width helper
//           used by load_scheduler and sched_timer.
// Contents: sched_state_t, DEF_TIMEOUT/DEF_DWELL/DEF_GAP, cnt_width(), CNT_W
package load_sched_pkg;

  typedef enum logic [2:0] {IDLE, ARM, DWELL, RELEASE, ERR} sched_state_t;

  localparam int DEF_TIMEOUT = 4096;
  localparam int DEF_DWELL   = 1_000_000;
  localparam int DEF_GAP     = 4;

  // Counter only ever reaches (limit-1), so clog2 of the largest limit suffices.
  function automatic int cnt_width(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return (m < 2) ? 1 : $clog2(m);
  endfunction

  localparam int CNT_W = cnt_width(DEF_TIMEOUT, DEF_DWELL, DEF_GAP);

endpackage

// File: rtl/sched_timer.sv
// rtl/sched_timer.sv - shared cycle counter with terminal-count compare
// Purpose : up-counter cleared on every scheduler state entry; o_tc flags
//           that the count equals the terminal value chosen by the caller.
// Ports   : i_clk, i_rst (sync, active-high), i_clr (sync clear), i_en (count),
//           i_term [CNT_W] terminal value, o_tc terminal-count flag
module sched_timer
  import load_sched_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_clr,
  input  logic             i_en,
  input  logic [CNT_W-1:0] i_term,
  output logic             o_tc
);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge i_clk) begin
    if (i_rst || i_clr) begin
      r_cnt <= '0;
    end else if (i_en) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign o_tc = (r_cnt == i_term);

endmodule

// File: rtl/load_scheduler.sv
// rtl/load_scheduler.sv - sequences program-slot loads for the demo program driver
// Purpose : picks a slot, raises drive, waits for load done (with watchdog),
//           holds the processor running for DWELL cycles, then drops drive for
//           GAP cycles. Optional auto-cycling over all slots when the macro
//           LOAD_SCHED_AUTO_EN is defined.
// Ports   : clk, rst (sync, active-high), start_in/stop_in/next_in (1-cycle pulses),
//           drv_done_in (driver done), drive_out (level), slot_out [SLOT_W],
//           busy_out (ARM/DWELL/RELEASE), err_out (sticky watchdog), loads_out [8]
module load_scheduler
  import load_sched_pkg::*;
#(
  parameter int NSLOTS  = 7,
  parameter int SLOT_W  = $clog2(NSLOTS),
  parameter int TIMEOUT = DEF_TIMEOUT,
  parameter int DWELL   = DEF_DWELL,
  parameter int GAP     = DEF_GAP
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_in,
  input  logic              stop_in,
  input  logic              next_in,
  input  logic              drv_done_in,
  output logic              drive_out,
  output logic [SLOT_W-1:0] slot_out,
  output logic              busy_out,
  output logic              err_out,
  output logic [7:0]        loads_out
);

  // The DWELL parameter shadows the state name, so the state is always qualified.
  localparam sched_state_t S_DWELL = load_sched_pkg::DWELL;
  localparam int           TMR_W   = cnt_width(TIMEOUT, DWELL, GAP);

`ifdef LOAD_SCHED_AUTO_EN
  localparam bit AUTO = 1'b1;
`else
  localparam bit AUTO = 1'b0;
`endif

  sched_state_t      r_state, w_state_nxt;
  logic              r_drive, r_busy, r_err, r_stop_q, r_next_q;
  logic [SLOT_W-1:0] r_slot, w_slot_nxt;
  logic [7:0]        r_loads, w_loads_nxt;
  logic              w_err_nxt, w_stop_nxt, w_next_nxt;
  logic              w_drive_nxt, w_busy_nxt, w_tc;
  logic [TMR_W-1:0]  w_term;

  function automatic logic [SLOT_W-1:0] slot_inc(input logic [SLOT_W-1:0] s);
    return (s == SLOT_W'(NSLOTS - 1)) ? '0 : s + SLOT_W'(1);
  endfunction

  always_comb begin
    case (r_state)
      ARM:     w_term = TMR_W'(TIMEOUT - 1);
      S_DWELL: w_term = TMR_W'(DWELL - 1);
      default: w_term = TMR_W'(GAP - 1);
    endcase
  end

  sched_timer #(.CNT_W(TMR_W)) u_timer (
    .i_clk  (clk),
    .i_rst  (rst),
    .i_clr  (w_state_nxt != r_state),
    .i_en   (r_busy),
    .i_term (w_term),
    .o_tc   (w_tc)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_slot_nxt  = r_slot;
    w_err_nxt   = r_err;
    w_loads_nxt = r_loads;
    w_stop_nxt  = r_stop_q;
    w_next_nxt  = r_next_q;
    case (r_state)
      IDLE: begin
        if (next_in)  w_slot_nxt  = slot_inc(r_slot);
        if (start_in) w_state_nxt = ARM;
      end
      ARM: begin
        if (stop_in) w_stop_nxt = 1'b1;
        if (next_in) w_next_nxt = 1'b1;
        // A load in flight is never cut short: done has priority over the watchdog.
        if (drv_done_in) begin
          if (r_loads != 8'hFF) w_loads_nxt = r_loads + 8'd1;
          w_state_nxt = w_stop_nxt ? RELEASE : S_DWELL;
        end else if (w_tc) begin
          // Drive drops on this edge, so a pending slot step can be applied now.
          if (w_next_nxt) w_slot_nxt = slot_inc(r_slot);
          w_state_nxt = ERR;
          w_err_nxt   = 1'b1;
          w_stop_nxt  = 1'b0;
          w_next_nxt  = 1'b0;
        end
      end
      S_DWELL: begin
        if (next_in) w_next_nxt = 1'b1;
        if (stop_in) begin
          w_stop_nxt  = 1'b1;
          w_state_nxt = RELEASE;
        end else if (w_tc) begin
          w_state_nxt = RELEASE;
        end
      end
      RELEASE: begin
        if (stop_in) w_stop_nxt = 1'b1;
        if (next_in) w_next_nxt = 1'b1;
        if (w_tc) begin
          // Manual and automatic advance merge into a single step.
          if (w_next_nxt || (AUTO && !w_stop_nxt)) w_slot_nxt = slot_inc(r_slot);
          w_state_nxt = (w_stop_nxt || !AUTO) ? IDLE : ARM;
          w_stop_nxt  = 1'b0;
          w_next_nxt  = 1'b0;
        end
      end
      ERR: begin
        if (next_in) w_slot_nxt = slot_inc(r_slot);
        if (start_in) begin
          w_state_nxt = ARM;
          w_err_nxt   = 1'b0;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
    w_drive_nxt = (w_state_nxt == ARM) || (w_state_nxt == S_DWELL);
    w_busy_nxt  = w_drive_nxt || (w_state_nxt == RELEASE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= IDLE;
      r_slot   <= '0;
      r_drive  <= 1'b0;
      r_busy   <= 1'b0;
      r_err    <= 1'b0;
      r_loads  <= '0;
      r_stop_q <= 1'b0;
      r_next_q <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_slot   <= w_slot_nxt;
      r_drive  <= w_drive_nxt;
      r_busy   <= w_busy_nxt;
      r_err    <= w_err_nxt;
      r_loads  <= w_loads_nxt;
      r_stop_q <= w_stop_nxt;
      r_next_q <= w_next_nxt;
    end
  end

  assign drive_out = r_drive;
  assign slot_out  = r_slot;
  assign busy_out  = r_busy;
  assign err_out   = r_err;
  assign loads_out = r_loads;

endmodule
